mem_port_ctrl: RTL and testbench

Single-port memory arbiter and pipeline stall controller for the five-stage RISC-V core. It shares one memory bus between instruction fetch (IF) and the MEM stage, with MEM getting fixed priority. It merges bus-wait stalls with the ID and EX stall requests into the `stall[5:0]` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.

---
 rtl/mem_port_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
// Single-port memory arbiter and pipeline stall controller. One memory bus is
// shared between instruction fetch (IF) and the MEM stage, with MEM given fixed
// priority. Bus-wait stalls are merged with the ID/EX stall requests into the
// stall vector for the pc, if_id, id_ex, ex_mem, mem_wb and wb registers.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : a wait counter aborts a bus access after TIMEOUT wait cycles
//               without ack; the owner gets done with rdata=0 and o_bus_err=1.
//   Undefined : WAIT holds until ack; o_bus_err is tied to 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_if_req/addr     fetch request (held until o_if_done) and address
//   o_if_rdata/done   fetched word, one-cycle completion pulse
//   i_mem_req/we/addr/wdata/be
//                     load/store request (held until o_mem_done)
//   o_mem_rdata/done  load data, one-cycle completion pulse
//   o_bus_req/we/addr/wdata/be
//                     bus request and attributes (stable while o_bus_req=1)
//   i_bus_ack/rdata   bus completion and read data
//   o_bus_err         one-cycle timeout pulse
//   i_stallreq_id/ex  load-use and multi-cycle ALU stall requests
//   o_stall[5:0]      1 = stop; bit 0 pc .. bit 5 wb
module mem_port_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_done,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_be,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_done,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_err,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  output logic [5:0]  o_stall
);

  typedef enum logic [1:0] {
    IDLE,
    IF_WAIT,
    MEM_WAIT,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner_mem;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_err;
  logic        w_in_wait;
  logic        w_timeout;
  logic        w_if_pend;
  logic        w_mem_pend;

  assign w_in_wait = (r_state == IF_WAIT) || (r_state == MEM_WAIT);

`ifdef BUS_TIMEOUT_EN
  localparam logic [4:0] LP_CNT_LAST = 5'(TIMEOUT - 1);

  logic [4:0] r_wait_cnt;

  // WAIT is only ever entered from IDLE, so clearing while idle is the same
  // as clearing on entry to a WAIT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_wait_cnt <= '0;
    end else if (w_in_wait && !i_bus_ack) begin
      r_wait_cnt <= r_wait_cnt + 5'd1;
    end
  end

  assign w_timeout = w_in_wait && !i_bus_ack && (r_wait_cnt == LP_CNT_LAST);
`else
  // TIMEOUT has no effect in this build; it stays so overrides remain legal.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_mem_req) begin
          w_next = MEM_WAIT;
        end else if (i_if_req) begin
          w_next = IF_WAIT;
        end
      end
      IF_WAIT, MEM_WAIT: begin
        if (i_bus_ack || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_mem <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_mem_req) begin
            r_owner_mem <= 1'b1;
            r_bus_we    <= i_mem_we;
            r_bus_addr  <= i_mem_addr;
            r_bus_wdata <= i_mem_wdata;
            r_bus_be    <= i_mem_be;
          end else if (i_if_req) begin
            r_owner_mem <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= i_if_addr;
            r_bus_be    <= '1;
          end
        end
        IF_WAIT, MEM_WAIT: begin
          if (i_bus_ack) begin
            if (r_owner_mem) begin
              r_mem_rdata <= i_bus_rdata;
            end else begin
              r_if_rdata <= i_bus_rdata;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_owner_mem) begin
              r_mem_rdata <= '0;
            end else begin
              r_if_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bus_req   = w_in_wait;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_be    = r_bus_be;
  assign o_bus_err   = r_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_rdata = r_mem_rdata;
  assign o_if_done   = (r_state == RESP) && !r_owner_mem;
  assign o_mem_done  = (r_state == RESP) && r_owner_mem;

  assign w_mem_pend = i_mem_req && !o_mem_done;
  assign w_if_pend  = i_if_req && !o_if_done;

  always_comb begin
    o_stall = '0;
    if (w_mem_pend) begin
      o_stall = 6'b011111;
    end else if (i_stallreq_ex) begin
      o_stall = 6'b001111;
    end else if (i_stallreq_id) begin
      o_stall = 6'b000111;
    end else if (w_if_pend) begin
      o_stall = 6'b000011;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic [5:0]  stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(
`ifdef BUS_TIMEOUT_EN
    .TIMEOUT(4)
`else
    .TIMEOUT(16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_rdata   (if_rdata),
    .o_if_done    (if_done),
    .i_mem_req    (mem_req),
    .i_mem_we     (mem_we),
    .i_mem_addr   (mem_addr),
    .i_mem_wdata  (mem_wdata),
    .i_mem_be     (mem_be),
    .o_mem_rdata  (mem_rdata),
    .o_mem_done   (mem_done),
    .o_bus_req    (bus_req),
    .o_bus_we     (bus_we),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .o_bus_be     (bus_be),
    .i_bus_ack    (bus_ack),
    .i_bus_rdata  (bus_rdata),
    .o_bus_err    (bus_err),
    .i_stallreq_id(stallreq_id),
    .i_stallreq_ex(stallreq_ex),
    .o_stall      (stall)
  );

  // Stall rules: pending MEM > EX request > ID request > pending IF.
  function automatic logic [5:0] exp_stall(input logic mreq, input logic mdone,
                                           input logic ireq, input logic idone,
                                           input logic sid, input logic sex);
    if (mreq && !mdone) return 6'b011111;
    if (sex)            return 6'b001111;
    if (sid)            return 6'b000111;
    if (ireq && !idone) return 6'b000011;
    return 6'b000000;
  endfunction

  // One bus access: requests are already driven and the DUT is idle, so the
  // next edge samples them. Ack arrives after 'waits' empty wait cycles.
  task automatic run_access(input bit is_mem, input logic [31:0] addr,
                            input logic we, input logic [31:0] wdata,
                            input logic [3:0] be, input int unsigned waits,
                            input logic [31:0] rdata, input string tag);
    logic       e_we;
    logic [3:0] e_be;
    logic [5:0] e_st;
    e_we = is_mem ? we : 1'b0;
    e_be = is_mem ? be : 4'hF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    for (int unsigned i = 0; i <= waits; i++) begin
      if (i == waits) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata;
      end
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== addr || bus_we !== e_we || bus_be !== e_be ||
          (is_mem && bus_wdata !== wdata) || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL %s bus cyc%0d: req=%b addr=%h we=%b be=%h wdata=%h err=%b; want req=1 addr=%h we=%b be=%h wdata=%h err=0",
                 tag, i, bus_req, bus_addr, bus_we, bus_be, bus_wdata, bus_err, addr, e_we, e_be, wdata);
      end
      e_st = exp_stall(mem_req, 1'b0, if_req, 1'b0, stallreq_id, stallreq_ex);
      checks++;
      if (stall !== e_st || if_done !== 1'b0 || mem_done !== 1'b0) begin
        errors++;
        $display("FAIL %s wait cyc%0d: stall=%b if_done=%b mem_done=%b; want stall=%b dones=0",
                 tag, i, stall, if_done, mem_done, e_st);
      end
      @(posedge clk); #1;
    end
    bus_ack   = 1'($urandom % 2);
    bus_rdata = $urandom;
    @(negedge clk);
    e_st = exp_stall(mem_req, is_mem, if_req, !is_mem, stallreq_id, stallreq_ex);
    checks++;
    if (if_done !== !is_mem || mem_done !== is_mem || bus_req !== 1'b0 || bus_err !== 1'b0 ||
        (is_mem ? mem_rdata : if_rdata) !== rdata || stall !== e_st) begin
      errors++;
      $display("FAIL %s resp: if_done=%b mem_done=%b bus_req=%b err=%b rdata=%h stall=%b; want if_done=%b mem_done=%b bus_req=0 err=0 rdata=%h stall=%b",
               tag, if_done, mem_done, bus_req, bus_err, is_mem ? mem_rdata : if_rdata, stall,
               !is_mem, is_mem, rdata, e_st);
    end
  endtask

  // The cycle following a response: must be idle with no bus request.
  task automatic idle_cycle(input string tag);
    logic [5:0] e_st;
    @(posedge clk); #1;
    bus_ack   = 1'($urandom % 2);
    bus_rdata = $urandom;
    @(negedge clk);
    e_st = exp_stall(mem_req, 1'b0, if_req, 1'b0, stallreq_id, stallreq_ex);
    checks++;
    if (bus_req !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0 || bus_err !== 1'b0 || stall !== e_st) begin
      errors++;
      $display("FAIL %s idle: bus_req=%b if_done=%b mem_done=%b err=%b stall=%b; want 0 0 0 0 stall=%b",
               tag, bus_req, if_done, mem_done, bus_err, stall, e_st);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_be = '0; bus_ack = 1'b0; bus_rdata = '0;
    stallreq_id = 1'b0; stallreq_ex = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 ||
        bus_be !== 4'h0 || if_done !== 1'b0 || mem_done !== 1'b0 || bus_err !== 1'b0 ||
        if_rdata !== 32'h0 || mem_rdata !== 32'h0 || stall !== 6'b0) begin
      errors++;
      $display("FAIL reset: req=%b we=%b addr=%h wdata=%h be=%h ifd=%b md=%b err=%b ird=%h mrd=%h stall=%b; want all 0",
               bus_req, bus_we, bus_addr, bus_wdata, bus_be, if_done, mem_done, bus_err, if_rdata, mem_rdata, stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || stall !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: bus_req=%b stall=%b; want 0 000000", bus_req, stall);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    run_access(1'b0, 32'h100, 1'b0, 32'h0, 4'hF, 2, 32'h0000_0013, "fetch");
    if_req = 1'b0;
    idle_cycle("fetch");
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'hF;
    run_access(1'b1, 32'h1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, 32'h5A5A_0001, "prio_mem");
    mem_req = 1'b0;
    idle_cycle("prio_gap");
    run_access(1'b0, 32'h200, 1'b0, 32'h0, 4'hF, 0, 32'h0011_2233, "prio_if");
    if_req = 1'b0;
    idle_cycle("prio_end");
  endtask

  task automatic test_stall_merge();
    stallreq_id = 1'b1; stallreq_ex = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b001111 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_id_ex: stall=%b bus_req=%b; want 001111 0", stall, bus_req);
    end
    stallreq_ex = 1'b0;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++;
      $display("FAIL stall_id: stall=%b; want 000111", stall);
    end
    stallreq_id = 1'b0;
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      errors++;
      $display("FAIL stall_none: stall=%b; want 000000", stall);
    end
  endtask

  task automatic test_if_held();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if_req = 1'b1; if_addr = a;
    for (int k = 0; k < 3; k++) begin
      run_access(1'b0, a, 1'b0, 32'h0, 4'hF, 32'($urandom % 3), $urandom, "if_held");
      if (k == 2) if_req = 1'b0;
      idle_cycle("if_held_gap");
    end
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_be = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin
      errors++;
      $display("FAIL rst_mid_start: bus_req=%b addr=%h; want 1 00000040", bus_req, bus_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || stall !== 6'b0 || mem_done !== 1'b0 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: bus_req=%b stall=%b mem_done=%b if_done=%b; want 0 000000 0 0",
               bus_req, stall, mem_done, if_done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || mem_done !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_late_ack: bus_req=%b mem_done=%b mem_rdata=%h; want 0 0 00000000",
               bus_req, mem_done, mem_rdata);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_random();
    int unsigned kind;
    logic [31:0] ia, ma, wd, rd;
    logic        we;
    logic [3:0]  be;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom % 3;
      stallreq_id = 1'($urandom % 2);
      stallreq_ex = 1'($urandom % 2);
      ia = $urandom; ma = $urandom; wd = $urandom; rd = $urandom;
      we = 1'($urandom % 2); be = 4'($urandom);
      if_addr = ia; mem_addr = ma; mem_we = we; mem_wdata = wd; mem_be = be;
      if_req  = (kind != 1);
      mem_req = (kind != 0);
      if (kind != 0) begin
        run_access(1'b1, ma, we, wd, be, $urandom % 4, rd, "rand_mem");
        mem_req = 1'b0;
        idle_cycle("rand_mem_gap");
      end
      if (kind != 1) begin
        run_access(1'b0, ia, 1'b0, 32'h0, 4'hF, $urandom % 4, $urandom ^ rd, "rand_if");
        if_req = 1'b0;
        idle_cycle("rand_if_gap");
      end
    end
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80; mem_be = 4'hF;
    run_access(1'b1, 32'h80, 1'b0, mem_wdata, 4'hF, 1, 32'hCAFE_F00D, "to_prime");
    mem_req = 1'b0;
    idle_cycle("to_prime_gap");
    mem_req = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1 || stall !== 6'b011111 || bus_err !== 1'b0 || mem_done !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait%0d: bus_req=%b stall=%b err=%b done=%b; want 1 011111 0 0",
                 i, bus_req, stall, bus_err, mem_done);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || bus_err !== 1'b1 || mem_rdata !== 32'h0 || bus_req !== 1'b0 || stall !== 6'b0) begin
      errors++;
      $display("FAIL timeout_resp: done=%b err=%b rdata=%h bus_req=%b stall=%b; want 1 1 00000000 0 000000",
               mem_done, bus_err, mem_rdata, bus_req, stall);
    end
    mem_req = 1'b0;
    idle_cycle("timeout_end");
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_stall_merge();
    test_if_held();
    test_reset_mid();
    test_random();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
